fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the team's show-ahead `fifo`. On a start command it drains a programmed burst of words from the FIFO read port and presents them downstream on a valid/ready stream, flagging the last word and pulsing done at burst end. A 2-entry output buffer decouples downstream back-pressure from the FIFO read strobe, so `o_fifo_read` never depends combinationally on `i_ready`.

## Interface

Parameters:
- `len_data`, 32: word width; must match the attached FIFO.
- `max_burst`, 16: maximum burst length in words.
- `bl_w` (localparam), `$clog2(max_burst)+1`: width of the burst-length fields.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start a burst; sampled only in IDLE.
- `i_burst_len`  in  bl_w  burst length; latched together with `i_start`.
- `i_fifo_empty`  in  1  FIFO `o_empty`.
- `i_fifo_data`  in  len_data  FIFO `o_data`; show-ahead, valid in the same cycle whenever empty is low.
- `o_fifo_read`  out  1  FIFO `i_read` strobe.
- `o_valid`  out  1  downstream word valid.
- `o_data`  out  len_data  downstream word.
- `o_last`  out  1  final word of the burst; qualified by `o_valid`.
- `i_ready`  in  1  downstream accept.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse after the last word is accepted.

## Operation

- States:
  - IDLE:
    - Accepts `i_start`.
    - A burst length of 0 is ignored: the block stays in IDLE, with no done pulse.
    - A burst length above `max_burst` is clamped to `max_burst`.
    - Otherwise it latches `fetch_left = send_left = len` and moves to RUN.
  - RUN:
    - Fetches and sends words.
    - Moves to DONE on the edge where the word with `send_left == 1` is accepted.
  - DONE:
    - `o_done = 1` for exactly one cycle, then returns to IDLE.
- `i_start` is ignored in RUN and DONE. No queueing.
- Fetch rule: `o_fifo_read = (state == RUN) && !i_fifo_empty && (fetch_left != 0) && (occ < 2)`.
  - `occ` is the registered buffer occupancy, 0 to 2.
  - `o_fifo_read` is combinational from registered state and `i_fifo_empty` only.
  - On the fetch edge, `i_fifo_data` is written into the buffer tail and `fetch_left` decrements.
- Send rule: `o_valid = (occ != 0)` and `o_data = head`.
  - When `occ == 0`, `o_data` is all zeros.
  - A transfer occurs when `o_valid && i_ready`; the head is popped and `send_left` decrements.
  - `o_last = o_valid && (send_left == 1)`.
- Fetch and pop in the same cycle: `occ` is unchanged and the buffer order is preserved, with FIFO order equal to output order.
- Once `o_valid` is high, `o_data` and `o_last` must stay stable until the transfer occurs.
- FIFO empty mid-burst: `o_fifo_read` stays low and fetching resumes when empty deasserts. The burst does not time out.
- Counters are `bl_w` bits wide. `fetch_left` and `send_left` never underflow, because decrements are gated by non-zero.
- The block never reads more than the burst length. FIFO words beyond the burst stay in the FIFO.

## Timing

- Reset values: state IDLE, `occ = 0`, counters 0, `o_valid = 0`, `o_data = 0`, `o_last = 0`, `o_busy = 0`, `o_done = 0`, `o_fifo_read = 0`.
- Reset mid-burst clears everything immediately. Words already held in the buffer are discarded, and FIFO words not yet read remain in the FIFO.
- Latency, with the FIFO non-empty and `i_ready` high:
  - `i_start` sampled at edge 0.
  - RUN and `o_fifo_read` high in cycle 1.
  - `o_valid` high in cycle 2.
- Throughput: 1 word per cycle sustained, with `occ` settling at 1.
- A burst of N with no stalls gives `o_valid` in cycles 2 through N+1, `o_last` in cycle N+1, and `o_done` in cycle N+2. `o_busy` falls in cycle N+3.
- `i_ready` low for K cycles: the buffer fills to 2 and fetching stops. After `i_ready` rises, output resumes in the same cycle, with no bubble.
- Back-to-back bursts: a new `i_start` is accepted in the first IDLE cycle after DONE.

## Test plan

- Basic burst:
  - Stimulus: FIFO preloaded with 0x11, 0x22, 0x33, 0x44; `i_burst_len = 4`; `i_ready = 1`.
  - Response: the words appear in cycles 2–5, `o_last` is high with 0x44, `o_done` pulses in cycle 6, and FIFO count ends at 0.
- Back-pressure:
  - Stimulus: a burst of 6 with `i_ready` toggling 1,0,0,1,…
  - Response: no word is lost or duplicated, `o_data` is held stable while stalled, `occ` never exceeds 2, and `o_fifo_read` never fires with `occ == 2`.
- Partial drain and underrun:
  - Stimulus: FIFO holds 10 words and `i_burst_len = 3`. In a second run, a burst of 5 starts with 2 words present and 3 more are written 4 cycles later.
  - Response: exactly 3 reads occur and the FIFO count is 7. The second run stalls, then completes with 5 ordered words.
- Edge lengths:
  - Stimulus: `i_burst_len` of 0, then 1, then 31 with `max_burst = 16`.
  - Response:
    - Length 0: no reads and no done pulse.
    - Length 1: `o_valid` and `o_last` are high together in cycle 2.
    - Length 31: the burst is clamped to 16 words.
- Reset mid-burst and ignored start:
  - Stimulus: `rst_n` asserted low while `occ == 2` in a burst of 8, and `i_start` pulsed during RUN.
  - Response: all outputs go to 0 asynchronously, and the remaining FIFO words are intact. The extra `i_start` has no effect.

Source files
------------

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// fifo_burst_reader: drains a programmed burst from a show-ahead FIFO onto a
// valid/ready stream through a 2-entry skid buffer, with last flag and done pulse.
module fifo_burst_reader #(
   parameter  int len_data  = 32,
   parameter  int max_burst = 16,
   localparam int bl_w      = $clog2(max_burst) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic [bl_w-1:0]     i_burst_len,
   input  logic                i_fifo_empty,
   input  logic [len_data-1:0] i_fifo_data,
   output logic                o_fifo_read,
   output logic                o_valid,
   output logic [len_data-1:0] o_data,
   output logic                o_last,
   input  logic                i_ready,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [bl_w-1:0]     fetch_left;
   logic [bl_w-1:0]     send_left;
   logic [bl_w-1:0]     start_len;
   logic [1:0]          occ;
   logic [len_data-1:0] head;
   logic [len_data-1:0] tail;
   logic                accept;
   logic                fetch;
   logic                pop;

   always_comb begin
      start_len = i_burst_len;
      if (i_burst_len > bl_w'(max_burst)) begin
         start_len = bl_w'(max_burst);
      end
   end

   assign accept = (state == IDLE) && i_start && (i_burst_len != '0);
   assign fetch  = o_fifo_read;
   assign pop    = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = RUN;
         RUN:     if (pop && (send_left == bl_w'(1))) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Read strobe depends only on registered state and FIFO empty, never on i_ready.
   always_comb begin
      o_fifo_read = (state == RUN) && !i_fifo_empty && (fetch_left != '0) && (occ != 2'd2);
      o_valid     = (occ != 2'd0);
      o_data      = o_valid ? head : '0;
      o_last      = o_valid && (send_left == bl_w'(1));
      o_busy      = (state == RUN) || (state == DONE);
      o_done      = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_left <= '0;
         send_left  <= '0;
      end else if (accept) begin
         fetch_left <= start_len;
         send_left  <= start_len;
      end else begin
         if (fetch) begin
            fetch_left <= fetch_left - bl_w'(1);
         end
         if (pop && (send_left != '0)) begin
            send_left <= send_left - bl_w'(1);
         end
      end
   end

   // head is the oldest word; simultaneous fetch and pop keeps FIFO order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         case ({fetch, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  head <= i_fifo_data;
               end else begin
                  tail <= i_fifo_data;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= i_fifo_data;
               end else begin
                  head <= tail;
                  tail <= i_fifo_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// tb_fifo_burst_reader: directed checks of fifo_burst_reader against a
// behavioural show-ahead FIFO and a stream monitor.
module tb_fifo_burst_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [4:0]  i_burst_len = '0;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        o_fifo_read;
   logic        o_valid;
   logic [31:0] o_data;
   logic        o_last;
   logic        i_ready = 1'b1;
   logic        o_busy;
   logic        o_done;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:255];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   int          rd_total = 0;
   logic        push_req = 1'b0;
   logic [31:0] push_val = '0;
   logic        flush_req = 1'b0;

   logic [31:0] rx_data [$];
   logic        rx_last [$];
   int          occ_m = 0;
   int          viol = 0;
   int          done_cnt = 0;
   logic        held = 1'b0;
   logic [31:0] held_data = '0;
   logic        held_last = 1'b0;
   int          r0;
   int          d0;

   fifo_burst_reader #(.len_data(32), .max_burst(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_burst_len  (i_burst_len),
      .i_fifo_empty (fifo_empty),
      .i_fifo_data  (fifo_data),
      .o_fifo_read  (o_fifo_read),
      .o_valid      (o_valid),
      .o_data       (o_data),
      .o_last       (o_last),
      .i_ready      (i_ready),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_data  = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (flush_req) begin
         rd_ptr <= wr_ptr;
      end else if (o_fifo_read && (rd_ptr != wr_ptr)) begin
         rd_ptr   <= rd_ptr + 1;
         rd_total <= rd_total + 1;
      end
      if (push_req) begin
         mem[wr_ptr[7:0]] <= push_val;
         wr_ptr <= wr_ptr + 1;
      end
   end

   // Stream monitor: occupancy model, hold-while-stalled rule, accepted words.
   always @(posedge clk) begin
      if (!rst_n) begin
         occ_m = 0;
         held  = 1'b0;
      end else begin
         if (o_valid !== (occ_m != 0)) viol++;
         if (o_fifo_read && occ_m >= 2) viol++;
         if (held && (!o_valid || o_data !== held_data || o_last !== held_last)) viol++;
         held      = o_valid && !i_ready;
         held_data = o_data;
         held_last = o_last;
         if (o_valid && i_ready) begin
            rx_data.push_back(o_data);
            rx_last.push_back(o_last);
         end
         occ_m = occ_m + int'(o_fifo_read) - int'(o_valid && i_ready);
         if (occ_m > 2) viol++;
         if (o_done) done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] v);
      @(negedge clk);
      push_req = 1'b1;
      push_val = v;
      @(negedge clk);
      push_req = 1'b0;
   endtask

   task automatic flush_fifo();
      @(negedge clk);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
   endtask

   // Returns at the negedge of cycle 1 (start sampled at the edge in between).
   task automatic start_burst(input logic [4:0] len);
      @(negedge clk);
      i_start     = 1'b1;
      i_burst_len = len;
      @(negedge clk);
      i_start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int n = 0;
      while (o_done !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(o_done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #3;
      check("rst_valid", 64'(o_valid), 0);
      check("rst_data",  64'(o_data), 0);
      check("rst_last",  64'(o_last), 0);
      check("rst_busy",  64'(o_busy), 0);
      check("rst_done",  64'(o_done), 0);
      check("rst_read",  64'(o_fifo_read), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic burst of 4
      push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
      rx_data.delete(); rx_last.delete();
      start_burst(5'd4);
      check("b_c1_busy",  64'(o_busy), 1);
      check("b_c1_read",  64'(o_fifo_read), 1);
      check("b_c1_valid", 64'(o_valid), 0);
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         check("b_valid", 64'(o_valid), 1);
         check("b_data",  64'(o_data), 64'(32'h11 * (c - 1)));
         check("b_last",  64'(o_last), 64'(c == 5));
      end
      @(negedge clk);
      check("b_c6_done",  64'(o_done), 1);
      check("b_c6_valid", 64'(o_valid), 0);
      @(negedge clk);
      check("b_c7_busy",  64'(o_busy), 0);
      check("b_c7_done",  64'(o_done), 0);
      check("b_fifo_cnt", 64'(wr_ptr - rd_ptr), 0);

      // Back-pressure burst of 6 with an ignored start during RUN
      for (int i = 0; i < 6; i++) push_word(32'hA0 + 32'(i));
      rx_data.delete(); rx_last.delete();
      r0 = rd_total; d0 = done_cnt;
      start_burst(5'd6);
      for (int i = 0; i < 80 && o_done !== 1'b1; i++) begin
         i_ready     = ((i % 4) == 0) || ((i % 4) == 3);
         i_start     = (i == 2);
         i_burst_len = 5'd2;
         @(negedge clk);
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      check("bp_done", 64'(o_done), 1);
      check("bp_count", 64'(rx_data.size()), 6);
      for (int i = 0; i < 6; i++) begin
         check("bp_data", 64'(rx_data[i]), 64'(32'hA0 + 32'(i)));
         check("bp_last", 64'(rx_last[i]), 64'(i == 5));
      end
      repeat (3) @(negedge clk);
      check("bp_ign_busy", 64'(o_busy), 0);
      check("bp_ign_done", 64'(done_cnt - d0), 1);
      check("bp_reads",    64'(rd_total - r0), 6);
      check("bp_viol",     64'(viol), 0);

      // Partial drain: 3 of 10
      for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
      rx_data.delete(); rx_last.delete();
      r0 = rd_total;
      start_burst(5'd3);
      wait_done("pd_done", 40);
      check("pd_count", 64'(rx_data.size()), 3);
      for (int i = 0; i < 3; i++) check("pd_data", 64'(rx_data[i]), 64'(32'h100 + 32'(i)));
      check("pd_reads",    64'(rd_total - r0), 3);
      check("pd_fifo_cnt", 64'(wr_ptr - rd_ptr), 7);
      flush_fifo();

      // Underrun: 2 words present, 3 more arrive later
      push_word(32'h200); push_word(32'h201);
      rx_data.delete(); rx_last.delete();
      start_burst(5'd5);
      fork
         begin
            repeat (4) @(negedge clk);
            push_word(32'h202); push_word(32'h203); push_word(32'h204);
         end
         wait_done("ur_done", 100);
      join
      check("ur_count", 64'(rx_data.size()), 5);
      for (int i = 0; i < 5; i++) check("ur_data", 64'(rx_data[i]), 64'(32'h200 + 32'(i)));

      // Length 0 ignored, length 1, length 31 clamped to 16
      push_word(32'h301); push_word(32'h302);
      r0 = rd_total; d0 = done_cnt;
      start_burst(5'd0);
      repeat (4) @(negedge clk);
      check("l0_busy",  64'(o_busy), 0);
      check("l0_reads", 64'(rd_total - r0), 0);
      check("l0_done",  64'(done_cnt - d0), 0);
      start_burst(5'd1);
      @(negedge clk);
      check("l1_valid", 64'(o_valid), 1);
      check("l1_last",  64'(o_last), 1);
      check("l1_data",  64'(o_data), 64'h301);
      wait_done("l1_done", 10);
      check("l1_fifo_cnt", 64'(wr_ptr - rd_ptr), 1);
      for (int i = 0; i < 20; i++) push_word(32'h400 + 32'(i));
      rx_data.delete(); rx_last.delete();
      start_burst(5'd31);
      wait_done("l31_done", 100);
      check("l31_count", 64'(rx_data.size()), 16);
      check("l31_first", 64'(rx_data[0]), 64'h302);
      check("l31_final", 64'(rx_data[15]), 64'h40E);
      check("l31_lastf", 64'(rx_last[15]), 1);
      check("l31_fifo_cnt", 64'(wr_ptr - rd_ptr), 5);
      flush_fifo();

      // Reset mid-burst with the buffer full
      for (int i = 0; i < 10; i++) push_word(32'h500 + 32'(i));
      i_ready = 1'b0;
      start_burst(5'd8);
      @(negedge clk);
      @(negedge clk);
      check("rm_read_full", 64'(o_fifo_read), 0);
      check("rm_valid",     64'(o_valid), 1);
      check("rm_head",      64'(o_data), 64'h500);
      #2;
      rst_n = 1'b0;
      #1;
      check("rm_valid0", 64'(o_valid), 0);
      check("rm_data0",  64'(o_data), 0);
      check("rm_last0",  64'(o_last), 0);
      check("rm_busy0",  64'(o_busy), 0);
      check("rm_read0",  64'(o_fifo_read), 0);
      check("rm_fifo_cnt", 64'(wr_ptr - rd_ptr), 8);
      check("rm_fifo_head", 64'(fifo_data), 64'h502);
      @(negedge clk);
      rst_n   = 1'b1;
      i_ready = 1'b1;
      flush_fifo();
      check("final_viol", 64'(viol), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
